// File: rtl/avalon_mm_cpuif_pkg.sv
// Shared constants and helpers for the Avalon-MM to regblock cpuif bridge.
package avalon_mm_cpuif_pkg;

  localparam logic [1:0] AVMM_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AVMM_RESP_SLVERR = 2'b10;

  // Expand up to 8 byte enables into a 64-bit per-bit enable; callers truncate.
  function automatic logic [63:0] byteen_to_biten(input logic [7:0] be);
    logic [63:0] biten;
    biten = '0;
    for (int i = 0; i < 8; i++) begin
      biten[i*8 +: 8] = {8{be[i]}};
    end
    return biten;
  endfunction

  function automatic bit data_width_ok(input int unsigned w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64);
  endfunction

  function automatic bit depth_ok(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/avalon_mm_intf.sv
// Avalon-MM bus bundle; the bridge sits on the agent side.
interface avalon_mm_intf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                      read;
  logic                      write;
  logic                      waitrequest;
  logic [ADDR_WIDTH-1:0]     address;
  logic [DATA_WIDTH-1:0]     writedata;
  logic [DATA_WIDTH/8-1:0]   byteenable;
  logic                      readdatavalid;
  logic                      writeresponsevalid;
  logic [DATA_WIDTH-1:0]     readdata;
  logic [1:0]                response;

  modport agent (
    input  read, write, address, writedata, byteenable,
    output waitrequest, readdatavalid, writeresponsevalid, readdata, response
  );

  modport host (
    output read, write, address, writedata, byteenable,
    input  waitrequest, readdatavalid, writeresponsevalid, readdata, response
  );
endinterface

// File: rtl/avalon_mm_cpuif_txn_fifo.sv
// 1-bit in-order transaction-type FIFO (1 = write) with simultaneous push/pop.
module avalon_mm_cpuif_txn_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       push_data_i,
  input  logic                       pop_i,
  output logic                       head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Push is allowed into a full FIFO only alongside a pop; pop from an
  // empty FIFO only alongside a push (the pushed entry passes straight through).
  always_comb begin
    do_push  = push_i & (~full_o | pop_i);
    do_pop   = pop_i & (~empty_o | push_i);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/avalon_mm_cpuif_bridge.sv
// Avalon-MM agent front end converting host commands to regblock cpuif requests
// and cpuif acks back to registered Avalon read/write responses.
module avalon_mm_cpuif_bridge
  import avalon_mm_cpuif_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned CPUIF_ADDR_WIDTH = 32,
  parameter int unsigned MAX_OUTSTANDING  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  avalon_mm_intf.agent                avalon,
  output logic                        cpuif_req,
  output logic                        cpuif_req_is_wr,
  output logic [CPUIF_ADDR_WIDTH-1:0] cpuif_addr,
  output logic [DATA_WIDTH-1:0]       cpuif_wr_data,
  output logic [DATA_WIDTH-1:0]       cpuif_wr_biten,
  input  logic                        cpuif_req_stall_wr,
  input  logic                        cpuif_req_stall_rd,
  input  logic                        cpuif_rd_ack,
  input  logic                        cpuif_rd_err,
  input  logic [DATA_WIDTH-1:0]       cpuif_rd_data,
  input  logic                        cpuif_wr_ack,
  input  logic                        cpuif_wr_err,
  output logic                        protocol_err
);
  localparam int unsigned ADDR_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int unsigned CNT_W      = $clog2(MAX_OUTSTANDING) + 1;

  if (!data_width_ok(DATA_WIDTH)) begin : g_bad_data_width
    $error("avalon_mm_cpuif_bridge: DATA_WIDTH must be 8, 16, 32 or 64");
  end
  if (!depth_ok(MAX_OUTSTANDING)) begin : g_bad_depth
    $error("avalon_mm_cpuif_bridge: MAX_OUTSTANDING must be a power of two >= 2");
  end

  logic             req_c, is_wr_c, stall_c, wait_c, accept_c;
  logic             head_valid_c, head_is_wr_c, any_ack_c, rd_ok_c, wr_ok_c, pop_c, err_evt_c;
  logic             fifo_head, fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic                  rvalid_q, wvalid_q, perr_q, perr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;

  avalon_mm_cpuif_txn_fifo #(.DEPTH(MAX_OUTSTANDING)) u_txn_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept_c),
    .push_data_i (is_wr_c),
    .pop_i       (pop_c),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Command acceptance, ack matching against the in-order head, next response state.
  always_comb begin
    req_c   = avalon.read | avalon.write;
    is_wr_c = avalon.write;
    stall_c = is_wr_c ? cpuif_req_stall_wr : cpuif_req_stall_rd;
    wait_c   = req_c & (stall_c | fifo_full);
    accept_c = req_c & ~wait_c;

    // A same-cycle ack for a command accepted into an empty FIFO matches that command.
    head_valid_c = (fifo_count != '0) | accept_c;
    head_is_wr_c = fifo_empty ? is_wr_c : fifo_head;

    any_ack_c = cpuif_rd_ack | cpuif_wr_ack;
    rd_ok_c   = cpuif_rd_ack & head_valid_c & ~head_is_wr_c;
    wr_ok_c   = cpuif_wr_ack & head_valid_c & head_is_wr_c;
    pop_c     = any_ack_c & head_valid_c;
    err_evt_c = (avalon.read & avalon.write) | (cpuif_rd_ack & cpuif_wr_ack)
              | (any_ack_c & ~(rd_ok_c | wr_ok_c));

    rdata_d = rdata_q;
    resp_d  = resp_q;
    perr_d  = perr_q | err_evt_c;
    if (rd_ok_c) begin
      rdata_d = cpuif_rd_data;
      resp_d  = cpuif_rd_err ? AVMM_RESP_SLVERR : AVMM_RESP_OKAY;
    end else if (wr_ok_c) begin
      resp_d  = cpuif_wr_err ? AVMM_RESP_SLVERR : AVMM_RESP_OKAY;
    end
  end

  // Registered Avalon response path and sticky protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      rdata_q  <= '0;
      resp_q   <= AVMM_RESP_OKAY;
      perr_q   <= 1'b0;
    end else begin
      rvalid_q <= rd_ok_c;
      wvalid_q <= wr_ok_c;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
      perr_q   <= perr_d;
    end
  end

  assign avalon.waitrequest        = wait_c;
  assign avalon.readdatavalid      = rvalid_q;
  assign avalon.writeresponsevalid = wvalid_q;
  assign avalon.readdata           = rdata_q;
  assign avalon.response           = resp_q;

  assign cpuif_req       = accept_c;
  assign cpuif_req_is_wr = is_wr_c;
  assign cpuif_addr      = CPUIF_ADDR_WIDTH'(avalon.address) << ADDR_SHIFT;
  assign cpuif_wr_data   = avalon.writedata;
  assign cpuif_wr_biten  = is_wr_c ? DATA_WIDTH'(byteen_to_biten(8'(avalon.byteenable))) : '1;
  assign protocol_err    = perr_q;

endmodule

// File: tb/tb_avalon_mm_cpuif_bridge.sv
// Self-checking bench for avalon_mm_cpuif_bridge: queue-based reference model
// checked every cycle plus directed vectors with literal expectations.
module tb_avalon_mm_cpuif_bridge;
  localparam int unsigned MAX_OUT = 4;

  logic        clk, rst;
  logic        cpuif_req, cpuif_req_is_wr;
  logic [31:0] cpuif_addr, cpuif_wr_data, cpuif_wr_biten;
  logic        cpuif_req_stall_wr, cpuif_req_stall_rd;
  logic        cpuif_rd_ack, cpuif_rd_err, cpuif_wr_ack, cpuif_wr_err;
  logic [31:0] cpuif_rd_data;
  logic        protocol_err;

  avalon_mm_intf #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) av ();

  avalon_mm_cpuif_bridge #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .CPUIF_ADDR_WIDTH(32), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .avalon             (av),
    .cpuif_req          (cpuif_req),
    .cpuif_req_is_wr    (cpuif_req_is_wr),
    .cpuif_addr         (cpuif_addr),
    .cpuif_wr_data      (cpuif_wr_data),
    .cpuif_wr_biten     (cpuif_wr_biten),
    .cpuif_req_stall_wr (cpuif_req_stall_wr),
    .cpuif_req_stall_rd (cpuif_req_stall_rd),
    .cpuif_rd_ack       (cpuif_rd_ack),
    .cpuif_rd_err       (cpuif_rd_err),
    .cpuif_rd_data      (cpuif_rd_data),
    .cpuif_wr_ack       (cpuif_wr_ack),
    .cpuif_wr_err       (cpuif_wr_err),
    .protocol_err       (protocol_err)
  );

  int n_vec  = 0;
  int n_miss = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model, checked on every falling edge ----------------
  bit          mq[$];
  bit          m_rv, m_wv, m_perr, n_rv, n_wv, m_head;
  logic [31:0] m_rdata;
  logic [1:0]  m_resp;
  bit          c_req, c_stall, c_wait, c_acc;
  logic [31:0] e_biten;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_rv = 0; m_wv = 0; m_perr = 0; m_rdata = '0; m_resp = 2'b00;
    end else begin
      c_req   = av.read | av.write;
      c_stall = av.write ? cpuif_req_stall_wr : cpuif_req_stall_rd;
      c_wait  = c_req && (c_stall || (mq.size() >= MAX_OUT));
      c_acc   = c_req && !c_wait;
      chk("m_waitrequest", 64'(av.waitrequest), 64'(c_wait));
      chk("m_cpuif_req", 64'(cpuif_req), 64'(c_acc));
      if (c_acc) begin
        for (int b = 0; b < 4; b++)
          e_biten[b*8 +: 8] = (av.write && !av.byteenable[b]) ? 8'h00 : 8'hFF;
        chk("m_req_is_wr", 64'(cpuif_req_is_wr), 64'(av.write));
        chk("m_addr", 64'(cpuif_addr), (64'(av.address) * 4) & 64'hFFFF_FFFF);
        chk("m_biten", 64'(cpuif_wr_biten), 64'(e_biten));
        if (av.write) chk("m_wr_data", 64'(cpuif_wr_data), 64'(av.writedata));
      end
      chk("m_readdatavalid", 64'(av.readdatavalid), 64'(m_rv));
      chk("m_writeresponsevalid", 64'(av.writeresponsevalid), 64'(m_wv));
      chk("m_protocol_err", 64'(protocol_err), 64'(m_perr));
      if (m_rv) chk("m_readdata", 64'(av.readdata), 64'(m_rdata));
      if (m_rv || m_wv) chk("m_response", 64'(av.response), 64'(m_resp));

      // advance the model to what the next clock edge produces
      if (av.read && av.write) m_perr = 1;
      if (c_acc) mq.push_back(av.write);
      n_rv = 0; n_wv = 0;
      if (cpuif_rd_ack || cpuif_wr_ack) begin
        if (cpuif_rd_ack && cpuif_wr_ack) m_perr = 1;
        if (mq.size() == 0) m_perr = 1;
        else begin
          m_head = mq.pop_front();
          if (!m_head && cpuif_rd_ack) begin
            n_rv = 1; m_rdata = cpuif_rd_data; m_resp = cpuif_rd_err ? 2'b10 : 2'b00;
          end else if (m_head && cpuif_wr_ack) begin
            n_wv = 1; m_resp = cpuif_wr_err ? 2'b10 : 2'b00;
          end else m_perr = 1;
        end
      end
      m_rv = n_rv; m_wv = n_wv;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    av.read = 0; av.write = 0; av.address = '0; av.writedata = '0; av.byteenable = '0;
    cpuif_req_stall_wr = 0; cpuif_req_stall_rd = 0;
    cpuif_rd_ack = 0; cpuif_rd_err = 0; cpuif_rd_data = '0;
    cpuif_wr_ack = 0; cpuif_wr_err = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  // burst table: 6 reads against a 4-deep tracker, acks released one per cycle
  bit          t_rd  [12] = '{1,1,1,1,1,1,1,1,0,0,0,0};
  logic [31:0] t_adr [12] = '{0,1,2,3,4,4,4,5,0,0,0,0};
  bit          t_ack [12] = '{0,0,0,0,0,1,1,1,1,1,1,0};
  bit          t_wait[12] = '{0,0,0,0,1,1,0,0,0,0,0,0};
  logic [31:0] got[$];
  int          req_pulses;
  logic [31:0] ack_data;

  initial begin
    rst = 1;
    idle_inputs();
    #1;
    chk("reset_readdatavalid", 64'(av.readdatavalid), 64'd0);
    chk("reset_protocol_err", 64'(protocol_err), 64'd0);
    chk("reset_response", 64'(av.response), 64'd0);
    chk("reset_readdata", 64'(av.readdata), 64'd0);
    tick(); tick();
    rst = 0;

    // zero-wait back-to-back traffic with same-cycle acks
    tick();
    av.write = 1; av.address = 32'h10; av.writedata = 32'hDEADBEEF; av.byteenable = 4'b0101;
    cpuif_wr_ack = 1;
    #1;
    chk("wr_addr", 64'(cpuif_addr), 64'h40);
    chk("wr_biten", 64'(cpuif_wr_biten), 64'h00FF00FF);
    chk("wr_waitrequest", 64'(av.waitrequest), 64'd0);
    chk("wr_req", 64'(cpuif_req), 64'd1);
    tick();
    idle_inputs();
    av.read = 1; av.address = 32'h11; cpuif_rd_ack = 1; cpuif_rd_data = 32'hCAFE0001;
    #1;
    chk("wr_resp_valid", 64'(av.writeresponsevalid), 64'd1);
    chk("wr_resp_okay", 64'(av.response), 64'd0);
    chk("rd_biten_all_ones", 64'(cpuif_wr_biten), 64'hFFFFFFFF);
    tick();
    idle_inputs();
    av.write = 1; av.address = 32'h12; av.writedata = 32'h1; av.byteenable = 4'hF;
    cpuif_wr_ack = 1; cpuif_wr_err = 1;
    #1;
    chk("rd_valid", 64'(av.readdatavalid), 64'd1);
    chk("rd_data", 64'(av.readdata), 64'hCAFE0001);
    tick();
    idle_inputs();
    #1;
    chk("wr_err_valid", 64'(av.writeresponsevalid), 64'd1);
    chk("wr_err_slverr", 64'(av.response), 64'h2);

    // read held off by stall_rd for three cycles
    req_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      av.read = 1; av.address = 32'h20; cpuif_req_stall_rd = 1;
      #1;
      chk("stall_waitrequest", 64'(av.waitrequest), 64'd1);
      if (cpuif_req) req_pulses++;
    end
    tick();
    cpuif_req_stall_rd = 0;
    #1;
    if (cpuif_req) req_pulses++;
    tick();
    idle_inputs();
    #1;
    if (cpuif_req) req_pulses++;
    chk("stall_req_once", 64'(req_pulses), 64'd1);
    tick();
    cpuif_rd_ack = 1; cpuif_rd_data = 32'h12345678; cpuif_rd_err = 1;
    tick();
    idle_inputs();
    #1;
    chk("stall_rd_valid", 64'(av.readdatavalid), 64'd1);
    chk("stall_rd_data", 64'(av.readdata), 64'h12345678);
    chk("stall_rd_slverr", 64'(av.response), 64'h2);

    // six reads, tracker fills at four, then drains one ack per cycle
    got.delete();
    ack_data = 32'hA0;
    for (int c = 0; c < 12; c++) begin
      tick();
      idle_inputs();
      av.read = t_rd[c]; av.address = t_adr[c];
      if (t_ack[c]) begin
        cpuif_rd_ack = 1; cpuif_rd_data = ack_data; ack_data = ack_data + 1;
      end
      #1;
      if (t_rd[c]) chk("burst_waitrequest", 64'(av.waitrequest), 64'(t_wait[c]));
      if (av.readdatavalid) got.push_back(av.readdata);
    end
    chk("burst_resp_count", 64'(got.size()), 64'd6);
    for (int i = 0; i < got.size(); i++) chk("burst_order", 64'(got[i]), 64'h00A0 + 64'(i));

    // unsolicited write ack on an empty tracker
    tick();
    idle_inputs();
    cpuif_wr_ack = 1;
    #1;
    chk("pre_unsolicited_perr", 64'(protocol_err), 64'd0);
    tick();
    idle_inputs();
    #1;
    chk("unsolicited_no_wresp", 64'(av.writeresponsevalid), 64'd0);
    chk("unsolicited_perr", 64'(protocol_err), 64'd1);
    tick(); tick();
    chk("perr_sticky", 64'(protocol_err), 64'd1);

    // reset with two reads outstanding (one already answered)
    tick(); av.read = 1; av.address = 32'h30;
    tick(); av.address = 32'h31;
    tick(); idle_inputs();
    tick(); cpuif_rd_ack = 1; cpuif_rd_data = 32'h55; cpuif_rd_err = 1;
    tick(); idle_inputs();
    #2;
    rst = 1;
    #1;
    chk("async_rst_rvalid", 64'(av.readdatavalid), 64'd0);
    chk("async_rst_readdata", 64'(av.readdata), 64'd0);
    chk("async_rst_response", 64'(av.response), 64'd0);
    chk("async_rst_perr", 64'(protocol_err), 64'd0);
    tick(); tick();
    rst = 0;
    tick();
    cpuif_rd_ack = 1; cpuif_rd_data = 32'h66;
    tick();
    idle_inputs();
    #1;
    chk("late_ack_no_rvalid", 64'(av.readdatavalid), 64'd0);
    chk("late_ack_perr", 64'(protocol_err), 64'd1);

    // read and write together: treated as a write, flagged
    do_reset();
    tick();
    av.read = 1; av.write = 1; av.address = 32'h7; av.writedata = 32'h77; av.byteenable = 4'hF;
    cpuif_wr_ack = 1;
    #1;
    chk("rdwr_is_wr", 64'(cpuif_req_is_wr), 64'd1);
    tick();
    idle_inputs();
    #1;
    chk("rdwr_wresp", 64'(av.writeresponsevalid), 64'd1);
    chk("rdwr_perr", 64'(protocol_err), 64'd1);

    // both acks at once: the one matching the head is honoured
    do_reset();
    tick();
    av.write = 1; av.address = 32'h8; av.byteenable = 4'b0011;
    cpuif_wr_ack = 1; cpuif_rd_ack = 1; cpuif_rd_data = 32'h99;
    tick();
    idle_inputs();
    #1;
    chk("dual_ack_wresp", 64'(av.writeresponsevalid), 64'd1);
    chk("dual_ack_no_rvalid", 64'(av.readdatavalid), 64'd0);
    chk("dual_ack_perr", 64'(protocol_err), 64'd1);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
